// File: rtl/sha_round_ctrl_if.sv
// Block handshake plus scheduler/compression control bundle for sha_round_ctrl.
// Latency: none, wires only.
// Backpressure: blk_valid/blk_ready carry upstream flow control; hold stalls the round sequence.
interface sha_round_ctrl_if #(
    parameter int BLOCK_W = 512,
    parameter int IDX_W   = 6
);
    logic               blk_valid;
    logic               blk_ready;
    logic               blk_first;
    logic [BLOCK_W-1:0] blk_data;
    logic               hold;
    logic               abort;
    logic [BLOCK_W-1:0] w_block;
    logic               w_init;
    logic               w_next;
    logic [IDX_W-1:0]   round_idx;
    logic               round_en;
    logic               digest_init;
    logic               wv_load;
    logic               digest_update;
    logic               done;
    logic               aborted;

    // Upstream padder / stall sources drive the block and control inputs.
    modport master (
        output blk_valid, blk_first, blk_data, hold, abort,
        input  blk_ready, w_block, w_init, w_next, round_idx, round_en,
               digest_init, wv_load, digest_update, done, aborted
    );

    // The controller sits on this side.
    modport slave (
        input  blk_valid, blk_first, blk_data, hold, abort,
        output blk_ready, w_block, w_init, w_next, round_idx, round_en,
               digest_init, wv_load, digest_update, done, aborted
    );
endinterface

// File: rtl/sha_round_ctrl.sv
// SHA-256 single-block sequencer: registers a block, then strobes W scheduler and compression core.
// Latency: LOAD 1 cycle after handshake, NROUNDS round cycles (+1 per hold cycle), FINAL, then ready.
// Backpressure: blk_ready only in IDLE; hold freezes rounds; abort drops the block from LOAD/ROUNDS.
module sha_round_ctrl #(
    parameter int BLOCK_W = 512,
    parameter int NROUNDS = 64,
    parameter int IDX_W   = 6
) (
    input  logic              clk,
    input  logic              rst,
    sha_round_ctrl_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, LOAD, ROUNDS, FINAL} state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NROUNDS - 1);

    state_t             state_q;
    state_t             state_d;
    logic               first_q;
    logic               aborted_q;
    logic [IDX_W-1:0]   idx_q;
    logic [BLOCK_W-1:0] w_block_q;

    logic ready_c;
    logic w_init_c;
    logic wv_load_c;
    logic dinit_c;
    logic step_c;
    logic final_c;
    logic abort_take_c;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and state-decoded strobes; abort outranks hold, FINAL always completes.
    always_comb begin
        state_d      = state_q;
        ready_c      = 1'b0;
        w_init_c     = 1'b0;
        wv_load_c    = 1'b0;
        dinit_c      = 1'b0;
        step_c       = 1'b0;
        final_c      = 1'b0;
        abort_take_c = 1'b0;
        case (state_q)
            IDLE: begin
                ready_c = 1'b1;
                if (bus.blk_valid) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                w_init_c  = 1'b1;
                wv_load_c = 1'b1;
                dinit_c   = first_q;
                if (bus.abort) begin
                    abort_take_c = 1'b1;
                    state_d      = IDLE;
                end else begin
                    state_d = ROUNDS;
                end
            end
            ROUNDS: begin
                if (bus.abort) begin
                    abort_take_c = 1'b1;
                    state_d      = IDLE;
                end else if (!bus.hold) begin
                    step_c = 1'b1;
                    if (idx_q == LAST_IDX) begin
                        state_d = FINAL;
                    end
                end
            end
            FINAL: begin
                final_c = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Block capture, round counter and abort pulse; the block register only loads on an IDLE handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_block_q <= '0;
            first_q   <= 1'b0;
            idx_q     <= '0;
            aborted_q <= 1'b0;
        end else begin
            aborted_q <= abort_take_c;
            if (ready_c && bus.blk_valid) begin
                w_block_q <= bus.blk_data;
                first_q   <= bus.blk_first;
                idx_q     <= '0;
            end else if (abort_take_c) begin
                idx_q <= '0;
            end else if (step_c) begin
                idx_q <= (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
            end
        end
    end

    assign bus.blk_ready     = ready_c;
    assign bus.w_block       = w_block_q;
    assign bus.w_init        = w_init_c;
    assign bus.w_next        = step_c;
    assign bus.round_idx     = idx_q;
    assign bus.round_en      = step_c;
    assign bus.digest_init   = dinit_c;
    assign bus.wv_load       = wv_load_c;
    assign bus.digest_update = final_c;
    assign bus.done          = final_c;
    assign bus.aborted       = aborted_q;
endmodule
